// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: light codes, phase
// encoding and small constant-evaluation helpers used to size ports/registers.
package traffic_pkg;

  // Per-direction light codes; 2'b11 is never driven.
  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  // Controller phase; encoding 2'd3 is illegal and recovers to P_ALLRED.
  typedef enum logic [1:0] {
    P_GREEN  = 2'd0,
    P_YELLOW = 2'd1,
    P_ALLRED = 2'd2
  } phase_e;

  // Ceiling log2, for widths derived from parameters.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Largest of three values, for sizing the shared phase timer.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin successor selection for the green owner.
// Scans cur+1, cur+2, ... (mod N_DIR, excluding cur) and returns the first
// direction whose traffic bit is set; with no other requester it returns
// (cur+1) mod N_DIR.
//   traffic_i : per-direction vehicle-waiting sensor
//   cur_i     : current owner index
//   next_o    : selected next owner index (combinational)
module rr_next_dir #(
  parameter int unsigned N_DIR = 4,
  parameter int unsigned DIR_W = 2
) (
  input  logic [N_DIR-1:0] traffic_i,
  input  logic [DIR_W-1:0] cur_i,
  output logic [DIR_W-1:0] next_o
);

  int unsigned idx;
  logic        found;

  // Nearest requester walking forward from cur; the found flag keeps the first hit.
  always_comb begin
    found  = 1'b0;
    idx    = 0;
    next_o = DIR_W'((32'(cur_i) + 32'd1) % N_DIR);
    for (int unsigned s = 1; s < N_DIR; s++) begin
      idx = (32'(cur_i) + s) % N_DIR;
      for (int unsigned j = 0; j < N_DIR; j++) begin
        if (!found && (j == idx) && traffic_i[j]) begin
          next_o = DIR_W'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-direction traffic light controller. One direction at a time owns
// green/yellow; after green it passes through yellow and an all-red
// clearance before the next owner is chosen round-robin among waiting
// directions. All outputs are registered (Moore).
//   clk        : clock
//   reset      : synchronous, active-high reset
//   traffic    : per-direction vehicle-waiting sensor (level)
//   light      : per-direction light code, bits [2i+1:2i] for direction i
//   active_dir : index of the direction owning green/yellow
//   phase      : current phase code (0 green, 1 yellow, 2 all-red)
module traffic_light_ctrl_n
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR     = 4,
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  localparam int unsigned DIR_W    = clog2(N_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DIR-1:0]     traffic,
  output logic [2*N_DIR-1:0]   light,
  output logic [DIR_W-1:0]     active_dir,
  output logic [1:0]           phase
);

  localparam int unsigned T_MAX = max3(GREEN_MAX, YELLOW_T, ALLRED_T);
  localparam int unsigned TMR_W = clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] G_MIN_END = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] G_MAX_END = TMR_W'(GREEN_MAX - 1);
  localparam logic [TMR_W-1:0] Y_END     = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] A_END     = TMR_W'(ALLRED_T - 1);

  phase_e               phase_q, phase_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [2*N_DIR-1:0]   light_q, light_d;
  logic [DIR_W-1:0]     rr_next;
  logic                 own_req;
  logic                 other_req;

  // Light pattern for a given phase/owner: owner green or yellow, rest red.
  function automatic logic [2*N_DIR-1:0] light_decode(input phase_e ph,
                                                      input logic [DIR_W-1:0] dir);
    logic [2*N_DIR-1:0] l;
    for (int unsigned i = 0; i < N_DIR; i++) begin
      l[2*i +: 2] = L_RED;
      if (DIR_W'(i) == dir) begin
        if (ph == P_GREEN)       l[2*i +: 2] = L_GREEN;
        else if (ph == P_YELLOW) l[2*i +: 2] = L_YELLOW;
      end
    end
    return l;
  endfunction

  rr_next_dir #(
    .N_DIR (N_DIR),
    .DIR_W (DIR_W)
  ) u_rr_next_dir (
    .traffic_i (traffic),
    .cur_i     (dir_q),
    .next_o    (rr_next)
  );

  // Split requests into the owner's own sensor and everyone else's.
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    for (int unsigned j = 0; j < N_DIR; j++) begin
      if (DIR_W'(j) == dir_q) own_req   = traffic[j];
      else                    other_req = other_req | traffic[j];
    end
  end

  // Next-state: phase sequencing, owner hand-over and the shared phase timer.
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    // Only green can linger, so only green needs the saturating hold.
    if ((phase_q == P_GREEN) && (timer_q >= G_MAX_END)) timer_d = timer_q;
    else                                                 timer_d = timer_q + TMR_W'(1);

    case (phase_q)
      P_GREEN: begin
        if (other_req && (((timer_q >= G_MIN_END) && !own_req) || (timer_q >= G_MAX_END))) begin
          phase_d = P_YELLOW;
          timer_d = '0;
        end
      end
      P_YELLOW: begin
        if (timer_q >= Y_END) begin
          phase_d = P_ALLRED;
          timer_d = '0;
        end
      end
      P_ALLRED: begin
        if (timer_q >= A_END) begin
          phase_d = P_GREEN;
          dir_d   = rr_next;
          timer_d = '0;
        end
      end
      default: begin
        phase_d = P_ALLRED;
        timer_d = '0;
      end
    endcase

    light_d = light_decode(phase_d, dir_d);
  end

  // State and registered outputs; reset wins over any phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= P_GREEN;
      dir_q   <= '0;
      timer_q <= '0;
      light_q <= light_decode(P_GREEN, '0);
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      light_q <= light_d;
    end
  end

  assign light      = light_q;
  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule

// File: doc/traffic_light_ctrl_n.md
TRAFFIC_LIGHT_CTRL_N -- requirements
Module: traffic_light_ctrl_n

Interface
REQ-001 The block SHALL take parameters, one per line: name, default, meaning.
  N_DIR      4   number of approach directions, legal range 2..8
  GREEN_MIN  4   minimum green cycles, >=1
  GREEN_MAX  10  maximum green cycles when another direction is waiting, >=GREEN_MIN
  YELLOW_T   2   yellow cycles, >=1
  ALLRED_T   1   all-red clearance cycles, >=1
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
  clk         in   1                  clock
  reset       in   1                  reset, synchronous, active-high
  traffic     in   N_DIR              per-direction vehicle-waiting sensor, level
  light       out  2*N_DIR            per-direction light code; bits [2i+1:2i] belong to direction i
  active_dir  out  clog2(N_DIR)       index of the direction currently owning green/yellow
  phase       out  2                  current phase code

Function
REQ-003 Light codes SHALL be GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 SHALL never be driven.
REQ-004 Phase codes SHALL be P_GREEN=0, P_YELLOW=1, P_ALLRED=2; code 3 is illegal and SHALL recover to P_ALLRED.
REQ-005 Outputs SHALL be Moore, decoded only from registered state; traffic SHALL NOT combinationally affect any output.
REQ-006 In P_GREEN and P_YELLOW, light[active_dir] SHALL show GREEN or YELLOW respectively; all other directions SHALL show RED.
REQ-007 In P_ALLRED, every direction SHALL show RED.
REQ-008 The timer SHALL load 0 on every phase entry, increment by 1 each cycle, and saturate at GREEN_MAX-1; its width SHALL be clog2(max(GREEN_MAX,YELLOW_T,ALLRED_T)+1).
REQ-009 Define other_req = OR of traffic[j] for all j != active_dir.
REQ-010 P_GREEN to P_YELLOW SHALL occur when other_req=1 and either (timer>=GREEN_MIN-1 and traffic[active_dir]=0) or (timer>=GREEN_MAX-1).
REQ-011 With other_req=0, P_GREEN SHALL hold indefinitely while the timer stays saturated.
REQ-012 P_YELLOW SHALL last exactly YELLOW_T cycles and P_ALLRED exactly ALLRED_T cycles, regardless of traffic.
REQ-013 Once P_YELLOW is entered, it SHALL complete even if other_req drops.
REQ-014 On P_ALLRED exit, active_dir SHALL update to the first index k after the current one, scanning cyclically (cur+1, cur+2, ... mod N_DIR, excluding cur), with traffic[k]=1 in that cycle.
REQ-015 If no such k exists, active_dir SHALL update to (cur+1) mod N_DIR; the new phase SHALL be P_GREEN.
REQ-016 Under continuous requests on all directions, service SHALL be strict round-robin and no direction SHALL wait more than (N_DIR-1)*(GREEN_MAX+YELLOW_T+ALLRED_T) cycles.

Reset
REQ-017 While reset=1 at a clk edge, the block SHALL set phase=P_GREEN, active_dir=0 and timer=0; this overrides any phase, including mid-yellow and mid-all-red.
REQ-018 The reset output values SHALL be: light[1:0]=GREEN, all other light fields=RED, active_dir=0, phase=0.

Structure
REQ-019 A shared package traffic_pkg SHALL hold the light-code constants, the phase enum and the clog2 helper.
REQ-020 A sub-module rr_next_dir SHALL be the only sub-module; it is combinational, with inputs traffic and cur and output next index, and it implements REQ-014 and REQ-015.

Verification
All scenarios use default parameters unless stated.
REQ-021 Reset, traffic=0 for 50 cycles -> phase=P_GREEN, active_dir=0, light=8'b10101000 throughout.
REQ-022 traffic=4'b0101 held -> dir0 green for 10 cycles, yellow for 2, all-red for 1, then active_dir=2 green.
REQ-023 traffic=4'b1000 (dir0 empty) -> dir0 green for exactly 4 cycles, then yellow; after clearance, active_dir=3.
REQ-024 active_dir=3 green, traffic=4'b0110 -> wrap-around selects active_dir=1, not 2.
REQ-025 Request withdrawn during yellow (traffic drops to 0) -> yellow and all-red still complete, then fallback active_dir=(cur+1) mod 4.
REQ-026 reset asserted for 1 cycle mid-yellow with active_dir=2 -> next cycle active_dir=0, phase=P_GREEN, timer=0.
